// File: rtl/tcb_sub_mem.sv
// TCB subordinate backed by a word-addressed memory array.
// Fixed-latency response pipeline with stall backpressure and out-of-range flagging.
module tcb_sub_mem #(
    parameter int ADR = 32,
    parameter int DAT = 32,
    parameter int SIZ = 1024,
    parameter int DLY = 1
)(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_stl,
    input  logic           i_tcb_vld,
    output logic           o_tcb_rdy,
    input  logic           i_tcb_wen,
    input  logic [ADR-1:0] i_tcb_adr,
    input  logic [DAT-1:0] i_tcb_wdt,
    output logic [DAT-1:0] o_tcb_rdt,
    output logic           o_rsp,
    output logic           o_err
);

    localparam int OFF = $clog2(DAT/8);
    localparam int AW  = $clog2(SIZ);

    logic           w_trn;
    logic [ADR-1:0] w_wrd;
    logic           w_oor;
    logic [AW-1:0]  w_idx;
    logic [DAT-1:0] w_rd_dat;
    logic [DAT-1:0] w_rdt;

    logic [DAT-1:0] r_mem [SIZ];
    logic           r_vld [DLY];
    logic           r_rd  [DLY];
    logic           r_err [DLY];
    logic [DAT-1:0] r_dat [DLY];
    logic [DAT-1:0] r_hold;

    assign o_tcb_rdy = ~i_stl & ~i_rst;
    assign w_trn     = i_tcb_vld & o_tcb_rdy;

    // Range check uses the full shifted address so aliases above SIZ are caught.
    assign w_wrd    = i_tcb_adr >> OFF;
    assign w_oor    = (w_wrd >= ADR'(SIZ));
    assign w_idx    = w_wrd[AW-1:0];
    assign w_rd_dat = w_oor ? '0 : r_mem[w_idx];

    always_ff @(posedge i_clk) begin
        if (w_trn && i_tcb_wen && !w_oor) begin
            r_mem[w_idx] <= i_tcb_wdt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DLY; i++) begin
                r_vld[i] <= 1'b0;
                r_rd[i]  <= 1'b0;
                r_err[i] <= 1'b0;
                r_dat[i] <= '0;
            end
            r_hold <= '0;
        end else begin
            r_vld[0] <= w_trn;
            r_rd[0]  <= w_trn & ~i_tcb_wen;
            r_err[0] <= w_oor;
            r_dat[0] <= w_rd_dat;
            for (int i = 1; i < DLY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            r_hold <= w_rdt;
        end
    end

    // Read data tracks the final stage on read responses and holds otherwise.
    assign w_rdt     = (r_vld[DLY-1] && r_rd[DLY-1]) ? r_dat[DLY-1] : r_hold;
    assign o_tcb_rdt = w_rdt;
    assign o_rsp     = r_vld[DLY-1];
    assign o_err     = r_vld[DLY-1] & r_err[DLY-1];

endmodule

// File: doc/tcb_sub_mem.md
# tcb_sub_mem

TCB subordinate (responder) backed by a word-addressed memory array; it terminates a TCB manager's request channel and returns read data a fixed number of cycles after each transfer. It sits at the subordinate end of a TCB link, as the bench memory model or as small on-chip RAM behind a CPU/DMA manager. It provides ready backpressure through a stall input and flags out-of-range accesses.

## Interface
Parameters:
- ADR, 32, address width in bits (byte address)
- DAT, 32, data width in bits; must be a power of two and at least 8
- SIZ, 1024, memory depth in DAT-wide words; must be a power of two
- DLY, 1, response latency in cycles after the transfer cycle; legal range 1..4

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  reset, synchronous, active-high
- stl  input  1  stall request; forces tcb_rdy low while high
- tcb_vld  input  1  request valid from manager
- tcb_rdy  output  1  subordinate ready
- tcb_wen  input  1  write enable (1 write, 0 read)
- tcb_adr  input  ADR  byte address
- tcb_wdt  input  DAT  write data
- tcb_rdt  output  DAT  read data
- rsp  output  1  response strobe, one per transfer, DLY cycles after it
- err  output  1  out-of-range flag, qualified by rsp

## Operation
- Transfer (trn) = tcb_vld & tcb_rdy in a cycle; at most one per cycle.
- tcb_rdy = ~stl & ~rst (combinational); stl has no effect on transfers already accepted.
- Word index = tcb_adr >> log2(DAT/8); low byte-offset bits ignored.
- Out-of-range: word index >= SIZ (compare full-width shifted address, not a truncated index).
- Write transfer, in range: mem[index] <= tcb_wdt on the transfer edge. Out of range: no memory change.
- Read transfer, in range: captures mem[index] as of the transfer cycle (including a write in the previous cycle). Out of range: captures all zeros.
- Response pipeline: DLY stages, each holding {vld, rd, err, dat}. Stage 1 loads on every clock: vld=trn, rd=trn&~tcb_wen, err=out-of-range, dat=read value. Later stages shift unconditionally.
- Final stage drives: rsp = vld, err = vld & err.
- tcb_rdt updates only when final stage has vld & rd; otherwise holds the last read response value (write responses do not disturb it).
- Back-to-back transfers every cycle are sustained with no bubbles; pipeline never stalls (no response backpressure).
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (rst high at a rising edge): all pipeline stages cleared, tcb_rdt <= 0, rsp = 0, err = 0; tcb_rdy = 0 while rst is high. First transfer possible in the cycle after rst deasserts.
- Reset mid-operation discards all pending responses; no rsp pulse for transfers accepted within DLY cycles before reset. Memory writes already committed remain.
- Latency: transfer at cycle n gives rsp/err/tcb_rdt valid in cycle n+DLY.
- Read-after-write to the same word in consecutive cycles returns the new data.
- tcb_vld high with stl high: no transfer, no rsp; the manager's request is held and accepted in the first cycle stl drops.
- tcb_vld low with tcb_rdy high: no transfer; tcb_rdt unchanged.

## Test plan
- Reset: assert rst for 2 cycles with tcb_vld=1 -> tcb_rdy=0, rsp=0, err=0, tcb_rdt=0; no memory write occurs.
- Write 0xDEADBEEF to adr 0x10, then read 0x10 and 0x13 in consecutive cycles (DLY=1) -> rsp pulses in 3 consecutive cycles; tcb_rdt=0xDEADBEEF one cycle after each read; err=0.
- Stall: tcb_vld=1 read of 0x20 with stl=1 for 3 cycles -> no rsp during stall; transfer in first cycle stl=0; rsp exactly DLY cycles later.
- Out of range (SIZ=1024, DAT=32): write to 0x1000, then read 0x1000 -> err=1 with rsp for both; read returns 0; mem[0] unchanged.
- Latency sweep DLY=1..4: 16 back-to-back random reads/writes -> rsp train mirrors trn shifted by exactly DLY; tcb_rdt holds across write responses.
- Reset mid-flight, DLY=3: two reads accepted, rst asserted next cycle -> no rsp for either; tcb_rdt=0 after reset.
